alu_op_sequencer: RTL and testbench

//  Initiator side of the ALU interface. Accepts one operation request at a time over a valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU interface: it accepts one op at a time and holds the operands for the op's latency.
// It captures the ALU result into the Z register pair and pulses done, with err set when the op code is illegal.
module alu_op_sequencer #(
  parameter int OP_MIN   = 3,
  parameter int OP_MAX   = 17,
  parameter int MUL_OP   = 14,
  parameter int DIV_OP   = 15,
  parameter int MUL_WAIT = 4,
  parameter int DIV_WAIT = 8
) (
  input  logic        Clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [5:0]  alu_ctl,
  input  logic [31:0] alu_Zhigh,
  input  logic [31:0] alu_Zlow,
  output logic [31:0] Zhigh_reg,
  output logic [31:0] Zlow_reg,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int MAXW = (MUL_WAIT > DIV_WAIT) ? MUL_WAIT : DIV_WAIT;
  localparam int CW   = (MAXW < 2) ? 1 : $clog2(MAXW + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] OP_MIN_C = 6'(OP_MIN);
  localparam logic [5:0] OP_MAX_C = 6'(OP_MAX);
  localparam logic [5:0] MUL_OP_C = 6'(MUL_OP);
  localparam logic [5:0] DIV_OP_C = 6'(DIV_OP);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   zh_q, zh_d, zl_q, zl_d;
  logic          err_q, err_d;
  logic          legal;

  assign legal = (req_op >= OP_MIN_C) && (req_op <= OP_MAX_C);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    zh_d    = zh_q;
    zl_d    = zl_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          if (legal) begin
            state_d = S_EXEC;
            if (req_op == MUL_OP_C)      cnt_d = CW'(MUL_WAIT);
            else if (req_op == DIV_OP_C) cnt_d = CW'(DIV_WAIT);
            else                         cnt_d = CW'(1);
          end else begin
            // Illegal codes never reach the ALU; the Z regs are left untouched.
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          zh_d    = alu_Zhigh;
          zl_d    = alu_Zlow;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      zh_q    <= '0;
      zl_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      zh_q    <= zh_d;
      zl_q    <= zl_d;
      err_q   <= err_d;
    end
  end

  // Operands stay on the ALU inputs between ops; only the control code is gated to EXEC.
  assign alu_A     = a_q;
  assign alu_B     = b_q;
  assign alu_ctl   = (state_q == S_EXEC) ? op_q : 6'd0;
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q == S_EXEC) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign Zhigh_reg = zh_q;
  assign Zlow_reg  = zl_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. A behavioural ALU sits on the alu_* ports.
// A transaction-level model predicts the latency, the err flag and the Z register contents for each op.
module tb_alu_op_sequencer;

  localparam int MUL_WAIT = 4;
  localparam int DIV_WAIT = 8;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [31:0] alu_A, alu_B, alu_Zhigh, alu_Zlow, Zhigh_reg, Zlow_reg;
  logic [5:0]  alu_ctl;
  logic        busy, done, err;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_zh = '0, exp_zl = '0;

  alu_op_sequencer dut (
    .Clock(Clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ctl(alu_ctl),
    .alu_Zhigh(alu_Zhigh), .alu_Zlow(alu_Zlow),
    .Zhigh_reg(Zhigh_reg), .Zlow_reg(Zlow_reg),
    .busy(busy), .done(done), .err(err)
  );

  always #5 Clock = ~Clock;

  function automatic logic [63:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'd3:    return {32'd0, a + b};
      6'd4:    return {32'd0, a - b};
      6'd14:   return {32'd0, a} * {32'd0, b};
      6'd15:   return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: return {26'd0, op, a ^ b ^ {26'd0, op}};
    endcase
  endfunction

  logic [63:0] alu_res;
  assign alu_res   = alu_f(alu_ctl, alu_A, alu_B);
  assign alu_Zhigh = alu_res[63:32];
  assign alu_Zlow  = alu_res[31:0];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one op from an IDLE negedge and returns at the IDLE negedge after it completes.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    bit legal;
    int lat;
    bit seen;
    legal = (op >= 3) && (op <= 17);
    lat   = !legal ? 1 : (op == 14) ? MUL_WAIT + 1 : (op == 15) ? DIV_WAIT + 1 : 2;
    if (legal) {exp_zh, exp_zl} = alu_f(op, a, b);
    seen = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge Clock);
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge Clock);
      if (k == 1) begin
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 6'($urandom);
      end
      if (done) begin
        seen = 1;
        chk("latency", 64'(k), 64'(lat));
        chk("err", err, legal ? 1'b0 : 1'b1);
        chk("ctl_done", alu_ctl, 6'd0);
        chk("zhigh", Zhigh_reg, exp_zh);
        chk("zlow", Zlow_reg, exp_zl);
      end else begin
        chk("ctl_exec", alu_ctl, op);
        chk("a_exec", alu_A, a);
        chk("b_exec", alu_B, b);
        chk("ready_busy", {req_ready, busy}, 2'b01);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge Clock);
    chk("idle_flags", {req_ready, busy, done, err}, 4'b1000);
    chk("idle_ctl", alu_ctl, 6'd0);
    if (legal) chk("a_hold", alu_A, a);
  endtask

  initial begin
    #12;
    chk("rst_flags", {req_ready, busy, done, err}, 4'b1000);
    chk("rst_alu", {alu_A, alu_B, alu_ctl}, 70'd0);
    chk("rst_z", {Zhigh_reg, Zlow_reg}, 64'd0);
    @(negedge Clock);
    clear = 1'b0;
    @(negedge Clock);

    do_op(6'd3, 32'd16, 32'd4);
    chk("add_zlow", Zlow_reg, 32'd20);
    do_op(6'd40, 32'd16, 32'd4);
    chk("illegal_z", {Zhigh_reg, Zlow_reg}, {32'd0, 32'd20});
    do_op(6'd0, 32'd7, 32'd9);
    do_op(6'd14, 32'd16, 32'd4);
    chk("mul_zlow", Zlow_reg, 32'd64);
    do_op(6'd15, 32'd16, 32'd4);
    chk("div_z", {Zhigh_reg, Zlow_reg}, {32'd0, 32'd4});
    do_op(6'd18, 32'd1, 32'd2);
    do_op(6'd17, 32'hFFFF_FFFF, 32'h1234_5678);

    // Abort a divide part-way through EXEC.
    req_valid = 1'b1; req_op = 6'd15; req_a = 32'd16; req_b = 32'd4;
    @(posedge Clock);
    @(negedge Clock); req_valid = 1'b0;
    repeat (2) @(negedge Clock);
    #1 clear = 1'b1;
    #1;
    chk("clr_flags", {req_ready, busy, done, err}, 4'b1000);
    chk("clr_out", {alu_A, alu_B, alu_ctl, Zhigh_reg, Zlow_reg}, 134'd0);
    exp_zh = '0; exp_zl = '0;
    @(negedge Clock); clear = 1'b0;
    @(negedge Clock);
    chk("clr_nodone", {done, busy}, 2'b00);
    do_op(6'd4, 32'd16, 32'd4);
    chk("sub_zlow", Zlow_reg, 32'd12);

    begin : back_to_back
      logic [69:0] q[$];
      logic [69:0] item;
      logic [63:0] r;
      int nxt, ndone;
      bit acc;
      nxt = 3; ndone = 0;
      req_valid = 1'b1; req_op = 6'd3; req_a = $urandom; req_b = $urandom;
      for (int cyc = 0; cyc < 400 && ndone < 15; cyc++) begin
        if (done) begin
          ndone++;
          if (q.size() == 0) chk("spurious_done", 1, 0);
          else begin
            item = q.pop_front();
            r = alu_f(item[69:64], item[63:32], item[31:0]);
            chk("b2b_z", {Zhigh_reg, Zlow_reg}, r);
            chk("b2b_err", err, 1'b0);
            exp_zh = r[63:32]; exp_zl = r[31:0];
          end
        end
        acc = req_ready && req_valid;
        @(posedge Clock);
        #1;
        if (acc) begin
          q.push_back({req_op, req_a, req_b});
          nxt++;
          if (nxt > 17) req_valid = 1'b0;
          else begin
            req_op = 6'(nxt); req_a = $urandom; req_b = $urandom_range(1, 1000);
          end
        end
        @(negedge Clock);
      end
      chk("b2b_count", 64'(ndone), 64'd15);
      chk("b2b_left", 64'(q.size()), 64'd0);
      chk("b2b_sent", 64'(nxt), 64'd18);
      req_valid = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
    end

    for (int i = 0; i < 30; i++) begin
      logic [5:0] op;
      logic [31:0] b;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(3, 17));
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
      do_op(op, $urandom, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
